rs_station: RTL and testbench
=============================

Name: rs_station

Overview:
- Parametrised reservation station for the out-of-order core, the successor to the single-CDB ALU RS.
- It holds up to DEPTH renamed ALU/branch ops and stores separate operand tags and values.
- It snoops N_CDB result broadcast channels (ALU, LSB, ...) and issues the oldest ready entry to the ALU over a valid/ready handshake.
- It supports global flush on mispredict and a rdy-based global stall.

Parameters:
DEPTH, 16, number of entries (power of two, >= 2)
N_CDB, 2, number of result broadcast channels snooped
XLEN, 32, operand/result width
ROB_W, 4, ROB tag width
OP_W, 6, internal opcode width
CNT_W, $clog2(DEPTH)+1, width of occupancy count

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
rdy  in  1  global enable; low = freeze all state
flush  in  1  mispredict flush; drops all entries
in_valid  in  1  dispatch new op this cycle
in_op  in  OP_W  opcode
in_rob  in  ROB_W  destination ROB tag
in_rdy1  in  1  operand 1 value valid
in_v1  in  XLEN  operand 1 value (meaningful when in_rdy1)
in_q1  in  ROB_W  operand 1 producer tag (meaningful when !in_rdy1)
in_rdy2, in_v2, in_q2  in  1/XLEN/ROB_W  same for operand 2 (immediates dispatched with in_rdy2=1)
full  out  1  all entries used (registered state, combinational output)
count  out  CNT_W  number of used entries
cdb_valid  in  N_CDB  per-channel broadcast valid
cdb_tag  in  N_CDB*ROB_W  packed tags, channel k at [k*ROB_W +: ROB_W]
cdb_val  in  N_CDB*XLEN  packed results
iss_valid  out  1  issue slot holds an op
iss_ready  in  1  ALU accepts op this cycle
iss_op  out  OP_W  issued opcode
iss_v1, iss_v2  out  XLEN  issued operands
iss_rob  out  ROB_W  issued ROB tag

Behaviour:
- Reset: used, rdy1, rdy2 all 0; age matrix cleared; iss_valid=0; iss_op, iss_v1, iss_v2, iss_rob=0; count=0; full=0. Reset overrides rdy and flush.
- Priority: rst > !rdy (hold everything, including iss_* and the handshake) > flush > normal operation.
- Flush: clear all used bits and iss_valid in one cycle; in_valid in the same cycle is ignored. The next cycle shows count=0.
- Dispatch: accepted when in_valid && !full (full taken from current registered used).
  - Allocates the lowest-index free entry and marks it youngest in the age matrix.
  - in_valid while full is dropped silently; upstream must gate on full.
- Dispatch bypass: if an incoming operand is not ready and its tag matches any valid CDB channel in the same cycle, the entry captures cdb_val and sets rdyN=1 at allocation.
- Wakeup: each cycle, for every used entry with rdyN=0 and qN==cdb_tag[k] with cdb_valid[k], capture the value and set rdyN=1.
  - If several channels match, the lowest k wins.
  - Operand 1 and operand 2 are evaluated independently.
  - Both may wake from different channels in one cycle.
- Select: the candidate set is used && rdy1 && rdy2, using registered bits, so a wakeup becomes issuable the cycle after capture. The oldest candidate by the age matrix is chosen.
- Issue register:
  - If !iss_valid || iss_ready, load the selected entry into iss_*, set iss_valid=1, and clear that entry's used bit. This is 1-cycle latency from ready to iss_valid.
  - With no candidate, iss_valid becomes 0.
  - If iss_valid && !iss_ready, iss_* hold unchanged and no entry is freed.
- Simultaneous issue and dispatch: the slot freed by issue is not reusable in the same cycle; count updates by +1-1=0.
- count/full reflect registered used; full = (count==DEPTH).
- Tags compare on full ROB_W bits. Values are stored and forwarded without arithmetic.

Decomposition:
- Shared package/defines: OP_W, ROB_W, XLEN defaults, and CDB packing macros (index helpers).
- Sub-module rs_age_matrix holds a DEPTH x DEPTH older-than bit matrix. Its interface:
  - alloc one-hot input, which sets the new row to "younger than all used entries";
  - free one-hot input;
  - candidate mask input;
  - one-hot oldest output.
- The main module holds entry storage, wakeup logic and the issue register.

Test Plan:
- Reset, then dispatch op 0x01, rob=3, v1=5, v2=7, both ready, iss_ready=1 -> cycle+1 iss_valid=1, iss_v1=5, iss_v2=7, iss_rob=3; count returns to 0.
- Dispatch rob=2 waiting q1=9; next cycle cdb_valid[1]=1, tag=9, val=0xDEAD -> iss_valid two cycles after the CDB pulse with iss_v1=0xDEAD. A CDB tag of 8 causes no wakeup.
- Dispatch A (rob1, waiting), B (rob2, ready), then wake A -> B issues first. With both ready, the older of A and B issues first regardless of slot index.
- Fill DEPTH=16 entries all waiting -> full=1, count=16. A 17th in_valid is dropped. Waking one entry -> issue, then full=0.
- Hold iss_ready=0 with 3 ready entries -> iss_* stable, count=2 (one already moved to issue). Raise iss_ready -> the remaining two issue oldest-first on consecutive cycles.
- Flush with 5 entries, iss_valid=1 and in_valid=1 -> next cycle count=0 and iss_valid=0. Then drop rdy for 3 cycles mid-operation -> all outputs frozen, CDB pulses ignored.

Source files
------------

// File: rtl/rs_station_pkg.sv
// Shared default widths and CDB bus packing helpers for the reservation station.
package rs_station_pkg;

  localparam int DEF_DEPTH = 16;
  localparam int DEF_N_CDB = 2;
  localparam int DEF_XLEN  = 32;
  localparam int DEF_ROB_W = 4;
  localparam int DEF_OP_W  = 6;

  // Low bit of channel k in a packed per-channel bus whose fields are w bits wide.
  function automatic int cdb_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/rs_age_matrix.sv
// Older-than bit matrix: row i bit j set means entry i was allocated before entry j.
// Reports the single oldest entry among a candidate mask as a one-hot vector.
module rs_age_matrix #(
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] free,
  input  logic [DEPTH-1:0] cand,
  output logic [DEPTH-1:0] oldest
);

  logic [DEPTH-1:0] valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= '0;
    end else begin
      valid_reg <= (valid_reg & ~free) | alloc;
    end
  end

  // Rows are kept zero while an entry is idle, so a live row only ever
  // records entries allocated after it.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_row
    logic [DEPTH-1:0] row_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        row_reg <= '0;
      end else if (alloc[gi] || free[gi]) begin
        row_reg <= '0;
      end else if (valid_reg[gi]) begin
        row_reg <= row_reg | alloc;
      end
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_col
    logic [DEPTH-1:0] col;

    for (genvar gj = 0; gj < DEPTH; gj++) begin : g_bit
      assign col[gj] = g_row[gj].row_reg[gi];
    end

    assign oldest[gi] = cand[gi] && !(|(cand & col));
  end

endmodule

// File: rtl/rs_station.sv
// Reservation station: holds renamed ALU/branch ops, snoops N_CDB result buses,
// and issues the oldest fully-ready op to the ALU over a valid/ready slot.
module rs_station
  import rs_station_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int N_CDB = DEF_N_CDB,
  parameter int XLEN  = DEF_XLEN,
  parameter int ROB_W = DEF_ROB_W,
  parameter int OP_W  = DEF_OP_W,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [OP_W-1:0]        in_op,
  input  logic [ROB_W-1:0]       in_rob,
  input  logic                   in_rdy1,
  input  logic [XLEN-1:0]        in_v1,
  input  logic [ROB_W-1:0]       in_q1,
  input  logic                   in_rdy2,
  input  logic [XLEN-1:0]        in_v2,
  input  logic [ROB_W-1:0]       in_q2,
  output logic                   full,
  output logic [CNT_W-1:0]       count,
  input  logic [N_CDB-1:0]       cdb_valid,
  input  logic [N_CDB*ROB_W-1:0] cdb_tag,
  input  logic [N_CDB*XLEN-1:0]  cdb_val,
  output logic                   iss_valid,
  input  logic                   iss_ready,
  output logic [OP_W-1:0]        iss_op,
  output logic [XLEN-1:0]        iss_v1,
  output logic [XLEN-1:0]        iss_v2,
  output logic [ROB_W-1:0]       iss_rob
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DEPTH-1:0] used_reg;
  logic [DEPTH-1:0] rdy1_reg;
  logic [DEPTH-1:0] rdy2_reg;
  logic [OP_W-1:0]  op_reg  [DEPTH];
  logic [ROB_W-1:0] rob_reg [DEPTH];
  logic [ROB_W-1:0] q1_reg  [DEPTH];
  logic [ROB_W-1:0] q2_reg  [DEPTH];
  logic [XLEN-1:0]  v1_reg  [DEPTH];
  logic [XLEN-1:0]  v2_reg  [DEPTH];

  logic             iss_valid_reg;
  logic [OP_W-1:0]  iss_op_reg;
  logic [XLEN-1:0]  iss_v1_reg;
  logic [XLEN-1:0]  iss_v2_reg;
  logic [ROB_W-1:0] iss_rob_reg;

  // Returns {hit, value}; scanning from the top down lets the lowest channel win.
  function automatic logic [XLEN:0] cdb_lookup(
    input logic [ROB_W-1:0]       tag,
    input logic [N_CDB-1:0]       vld,
    input logic [N_CDB*ROB_W-1:0] tags,
    input logic [N_CDB*XLEN-1:0]  vals
  );
    logic [XLEN:0] hit;
    hit = '0;
    for (int k = N_CDB - 1; k >= 0; k--) begin
      if (vld[k] && tags[cdb_lo(k, ROB_W) +: ROB_W] == tag) begin
        hit = {1'b1, vals[cdb_lo(k, XLEN) +: XLEN]};
      end
    end
    return hit;
  endfunction

  logic            wake1 [DEPTH];
  logic            wake2 [DEPTH];
  logic [XLEN-1:0] wval1 [DEPTH];
  logic [XLEN-1:0] wval2 [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wake
    assign {wake1[gi], wval1[gi]} = cdb_lookup(q1_reg[gi], cdb_valid, cdb_tag, cdb_val);
    assign {wake2[gi], wval2[gi]} = cdb_lookup(q2_reg[gi], cdb_valid, cdb_tag, cdb_val);
  end

  logic            byp1_hit;
  logic            byp2_hit;
  logic [XLEN-1:0] byp1_val;
  logic [XLEN-1:0] byp2_val;

  assign {byp1_hit, byp1_val} = cdb_lookup(in_q1, cdb_valid, cdb_tag, cdb_val);
  assign {byp2_hit, byp2_val} = cdb_lookup(in_q2, cdb_valid, cdb_tag, cdb_val);

  logic [IDX_W-1:0] alloc_idx;
  logic [IDX_W-1:0] sel_idx;
  logic [DEPTH-1:0] cand;
  logic [DEPTH-1:0] oldest;
  logic [DEPTH-1:0] age_alloc;
  logic [DEPTH-1:0] age_free;
  logic             iss_load;
  logic             issue_fire;
  logic             dispatch;

  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!used_reg[i]) alloc_idx = IDX_W'(i);
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (oldest[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CNT_W'(used_reg[i]);
    end
  end

  assign full       = &used_reg;
  assign cand       = used_reg & rdy1_reg & rdy2_reg;
  assign iss_load   = !iss_valid_reg || iss_ready;
  assign issue_fire = rdy && !flush && iss_load && (|cand);
  assign dispatch   = rdy && !flush && in_valid && !full;
  assign age_alloc  = dispatch ? (DEPTH'(1) << alloc_idx) : '0;
  assign age_free   = (rdy && flush) ? '1 : (issue_fire ? oldest : '0);

  rs_age_matrix #(
    .DEPTH (DEPTH)
  ) u_age (
    .clk    (clk),
    .rst    (rst),
    .alloc  (age_alloc),
    .free   (age_free),
    .cand   (cand),
    .oldest (oldest)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      used_reg      <= '0;
      rdy1_reg      <= '0;
      rdy2_reg      <= '0;
      iss_valid_reg <= 1'b0;
      iss_op_reg    <= '0;
      iss_v1_reg    <= '0;
      iss_v2_reg    <= '0;
      iss_rob_reg   <= '0;
    end else if (rdy) begin
      if (flush) begin
        used_reg      <= '0;
        iss_valid_reg <= 1'b0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (used_reg[i] && !rdy1_reg[i] && wake1[i]) begin
            rdy1_reg[i] <= 1'b1;
            v1_reg[i]   <= wval1[i];
          end
          if (used_reg[i] && !rdy2_reg[i] && wake2[i]) begin
            rdy2_reg[i] <= 1'b1;
            v2_reg[i]   <= wval2[i];
          end
        end

        if (iss_load) begin
          iss_valid_reg <= |cand;
          if (|cand) begin
            iss_op_reg        <= op_reg[sel_idx];
            iss_v1_reg        <= v1_reg[sel_idx];
            iss_v2_reg        <= v2_reg[sel_idx];
            iss_rob_reg       <= rob_reg[sel_idx];
            used_reg[sel_idx] <= 1'b0;
          end
        end

        // alloc_idx comes from registered used bits, so a slot freed by
        // issue this cycle cannot be picked until next cycle.
        if (dispatch) begin
          used_reg[alloc_idx] <= 1'b1;
          op_reg[alloc_idx]   <= in_op;
          rob_reg[alloc_idx]  <= in_rob;
          q1_reg[alloc_idx]   <= in_q1;
          q2_reg[alloc_idx]   <= in_q2;
          rdy1_reg[alloc_idx] <= in_rdy1 | byp1_hit;
          rdy2_reg[alloc_idx] <= in_rdy2 | byp2_hit;
          v1_reg[alloc_idx]   <= in_rdy1 ? in_v1 : byp1_val;
          v2_reg[alloc_idx]   <= in_rdy2 ? in_v2 : byp2_val;
        end
      end
    end
  end

  assign iss_valid = iss_valid_reg;
  assign iss_op    = iss_op_reg;
  assign iss_v1    = iss_v1_reg;
  assign iss_v2    = iss_v2_reg;
  assign iss_rob   = iss_rob_reg;

endmodule

// File: tb/tb_rs_station.sv
// Directed plus randomized bench for rs_station against an age-ordered queue model.
module tb_rs_station;

  localparam int DEPTH = 16;
  localparam int N_CDB = 2;
  localparam int XLEN  = 32;
  localparam int ROB_W = 4;
  localparam int OP_W  = 6;
  localparam int CNT_W = 5;

  logic                   clk = 1'b0;
  logic                   rst, rdy, flush, in_valid;
  logic [OP_W-1:0]        in_op;
  logic [ROB_W-1:0]       in_rob, in_q1, in_q2;
  logic                   in_rdy1, in_rdy2;
  logic [XLEN-1:0]        in_v1, in_v2;
  logic                   full;
  logic [CNT_W-1:0]       count;
  logic [N_CDB-1:0]       cdb_valid;
  logic [N_CDB*ROB_W-1:0] cdb_tag;
  logic [N_CDB*XLEN-1:0]  cdb_val;
  logic                   iss_valid, iss_ready;
  logic [OP_W-1:0]        iss_op;
  logic [XLEN-1:0]        iss_v1, iss_v2;
  logic [ROB_W-1:0]       iss_rob;

  rs_station #(
    .DEPTH(DEPTH), .N_CDB(N_CDB), .XLEN(XLEN), .ROB_W(ROB_W), .OP_W(OP_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_op(in_op), .in_rob(in_rob),
    .in_rdy1(in_rdy1), .in_v1(in_v1), .in_q1(in_q1),
    .in_rdy2(in_rdy2), .in_v2(in_v2), .in_q2(in_q2),
    .full(full), .count(count),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_v1(iss_v1), .iss_v2(iss_v2), .iss_rob(iss_rob)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: queue front is the oldest waiting op; issue slot kept separately.
  typedef struct {
    logic [OP_W-1:0]  op;
    logic [ROB_W-1:0] rob;
    bit               r1;
    logic [XLEN-1:0]  v1;
    logic [ROB_W-1:0] q1;
    bit               r2;
    logic [XLEN-1:0]  v2;
    logic [ROB_W-1:0] q2;
  } ent_t;

  ent_t             mq[$];
  bit               m_iv;
  logic [OP_W-1:0]  m_op;
  logic [ROB_W-1:0] m_rob;
  logic [XLEN-1:0]  m_v1, m_v2;

  function automatic bit bus_hit(input logic [ROB_W-1:0] tag, output logic [XLEN-1:0] val);
    for (int k = 0; k < N_CDB; k++) begin
      if (cdb_valid[k] && cdb_tag[k*ROB_W +: ROB_W] == tag) begin
        val = cdb_val[k*XLEN +: XLEN];
        return 1'b1;
      end
    end
    val = '0;
    return 1'b0;
  endfunction

  task automatic model_edge();
    int              pick;
    bit              acc;
    bit              hit;
    logic [XLEN-1:0] v;
    ent_t            e;
    if (rst) begin
      mq.delete();
      m_iv = 0; m_op = '0; m_rob = '0; m_v1 = '0; m_v2 = '0;
    end else if (rdy) begin
      if (flush) begin
        mq.delete();
        m_iv = 0;
      end else begin
        acc = in_valid && (mq.size() < DEPTH);
        if (!m_iv || iss_ready) begin
          pick = -1;
          for (int i = 0; i < mq.size(); i++)
            if (pick < 0 && mq[i].r1 && mq[i].r2) pick = i;
          m_iv = (pick >= 0);
          if (pick >= 0) begin
            m_op = mq[pick].op; m_rob = mq[pick].rob;
            m_v1 = mq[pick].v1; m_v2 = mq[pick].v2;
            mq.delete(pick);
          end
        end
        for (int i = 0; i < mq.size(); i++) begin
          hit = bus_hit(mq[i].q1, v);
          if (!mq[i].r1 && hit) begin mq[i].r1 = 1; mq[i].v1 = v; end
          hit = bus_hit(mq[i].q2, v);
          if (!mq[i].r2 && hit) begin mq[i].r2 = 1; mq[i].v2 = v; end
        end
        if (acc) begin
          e.op = in_op; e.rob = in_rob; e.q1 = in_q1; e.q2 = in_q2;
          e.r1 = in_rdy1; e.v1 = in_v1; e.r2 = in_rdy2; e.v2 = in_v2;
          hit = bus_hit(in_q1, v);
          if (!in_rdy1 && hit) begin e.r1 = 1; e.v1 = v; end
          hit = bus_hit(in_q2, v);
          if (!in_rdy2 && hit) begin e.r2 = 1; e.v2 = v; end
          mq.push_back(e);
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    vectors++;
    chk("iss_valid", 32'(iss_valid), 32'(m_iv));
    chk("count", 32'(count), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    if (m_iv) begin
      chk("iss_op", 32'(iss_op), 32'(m_op));
      chk("iss_rob", 32'(iss_rob), 32'(m_rob));
      chk("iss_v1", iss_v1, m_v1);
      chk("iss_v2", iss_v2, m_v2);
    end
    in_valid = 0; cdb_valid = '0; flush = 0;
  endtask

  task automatic disp(input int op, input int rob, input bit r1, input logic [31:0] v1,
                      input int q1, input bit r2, input logic [31:0] v2, input int q2);
    in_valid = 1; in_op = OP_W'(op); in_rob = ROB_W'(rob);
    in_rdy1 = r1; in_v1 = v1; in_q1 = ROB_W'(q1);
    in_rdy2 = r2; in_v2 = v2; in_q2 = ROB_W'(q2);
  endtask

  task automatic bus(input int k, input int tag, input logic [31:0] val);
    cdb_valid[k] = 1'b1;
    cdb_tag[k*ROB_W +: ROB_W] = ROB_W'(tag);
    cdb_val[k*XLEN +: XLEN] = val;
  endtask

  initial begin
    rst = 1; rdy = 1; flush = 0; in_valid = 0; iss_ready = 1;
    in_op = '0; in_rob = '0; in_q1 = '0; in_q2 = '0;
    in_rdy1 = 0; in_rdy2 = 0; in_v1 = '0; in_v2 = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_val = '0;
    step(); step();
    rst = 0;
    chk("rst_iss_op", 32'(iss_op), 0);
    chk("rst_iss_v1", iss_v1, 0);
    chk("rst_iss_v2", iss_v2, 0);
    chk("rst_iss_rob", 32'(iss_rob), 0);

    // Both operands ready: issues the cycle after dispatch.
    disp(8'h01, 3, 1, 5, 0, 1, 7, 0); step();
    step();
    chk("t1_v1", iss_v1, 5); chk("t1_v2", iss_v2, 7); chk("t1_rob", 32'(iss_rob), 3);
    step();

    // Wakeup through channel 1; a non-matching tag must not wake.
    disp(8'h02, 2, 0, 0, 9, 1, 32'h11, 0); step();
    bus(1, 8, 32'hBEEF); step();
    bus(1, 9, 32'hDEAD); step();
    chk("t2_nowake", 32'(iss_valid), 0);
    step();
    chk("t2_v1", iss_v1, 32'hDEAD);
    step();

    // Ready younger op issues ahead of waiting older one.
    disp(8'h03, 1, 0, 0, 5, 1, 1, 0); step();
    disp(8'h04, 2, 1, 2, 0, 1, 2, 0); step();
    bus(0, 5, 32'hA5); step();
    chk("t3_first", 32'(iss_rob), 2);
    step();
    chk("t3_second", 32'(iss_rob), 1);
    step();

    // Older op in a higher slot wins once both are ready.
    disp(8'h05, 4, 0, 0, 6, 1, 4, 0); step();
    disp(8'h06, 5, 0, 0, 7, 1, 5, 0); step();
    bus(0, 6, 32'hC0); step();
    step();
    disp(8'h07, 6, 1, 6, 0, 1, 6, 0); bus(1, 7, 32'hD0); step();
    step();
    chk("t4_older", 32'(iss_rob), 5);
    step();
    chk("t4_younger", 32'(iss_rob), 6);
    step();

    // Fill every entry, drop the overflow dispatch, then drain one.
    for (int i = 0; i < DEPTH; i++) begin
      disp(8'h10 + i, i, 0, 0, i, 1, i, 0); step();
    end
    chk("t5_full", 32'(full), 1); chk("t5_count", 32'(count), 16);
    disp(8'h3F, 15, 1, 1, 0, 1, 1, 0); step();
    chk("t5_drop", 32'(count), 16);
    bus(0, 3, 32'h333); step();
    step();
    chk("t5_notfull", 32'(full), 0); chk("t5_rob", 32'(iss_rob), 3);
    disp(8'h01, 1, 1, 1, 0, 1, 1, 0); flush = 1; step();
    chk("t5_flush", 32'(count), 0);

    // Stalled issue slot holds its op; the rest drain oldest-first.
    iss_ready = 0;
    for (int i = 0; i < 3; i++) begin
      disp(8'h20 + i, 7 + i, 1, 32'h100 + i, 0, 1, 32'h200 + i, 0); step();
    end
    step(); step();
    chk("t6_count", 32'(count), 2); chk("t6_hold", 32'(iss_rob), 7);
    iss_ready = 1; step();
    chk("t6_next", 32'(iss_rob), 8);
    step();
    chk("t6_last", 32'(iss_rob), 9);
    step();

    // Flush with a held issue slot and a concurrent dispatch.
    iss_ready = 0;
    for (int i = 0; i < 6; i++) begin
      disp(8'h30 + i, i, 1, i, 0, 1, i, 0); step();
    end
    chk("t7_pre", 32'(count), 5);
    disp(8'h3A, 12, 1, 1, 0, 1, 1, 0); flush = 1; step();
    chk("t7_count", 32'(count), 0); chk("t7_iss", 32'(iss_valid), 0);

    // Freeze: rdy low ignores dispatch, CDB and handshake for 3 cycles.
    disp(8'h08, 10, 0, 0, 12, 1, 3, 0); step();
    disp(8'h09, 11, 1, 4, 0, 1, 5, 0); step();
    step();
    rdy = 0; iss_ready = 1;
    for (int i = 0; i < 3; i++) begin
      disp(8'h0A, 13, 1, 9, 0, 1, 9, 0); bus(0, 12, 32'hFEED); step();
      chk("t8_frozen", 32'(iss_rob), 11);
    end
    rdy = 1; step();
    bus(0, 12, 32'hABC); step();
    step();
    chk("t8_wake", iss_v1, 32'hABC);
    step();

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      rdy = ($urandom_range(0, 19) != 0);
      iss_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 2) != 0)
        disp($urandom_range(0, 63), $urandom_range(0, 15),
             1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 7),
             1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 7));
      for (int k = 0; k < N_CDB; k++)
        if ($urandom_range(0, 2) == 0) bus(k, $urandom_range(0, 7), $urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
